// File: rtl/ipid_pkg.sv
// Shared definitions for the IP-ID streaming link (producer ipid_stream and consumer ipid_assemble).
package ipid_pkg;

  localparam int IPID_W_DFLT  = 256;
  localparam int CHUNK_W_DFLT = 16;
  localparam int NUM_CHUNKS   = IPID_W_DFLT / CHUNK_W_DFLT;

  typedef logic [IPID_W_DFLT-1:0] ipid_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } ipid_asm_state_e;

endpackage

// File: rtl/ipid_assemble.sv
// Reassembles an MSB-first chunk stream into one IP ID, compares it with a golden value,
// and aborts the frame if the producer stalls for too long.
module ipid_assemble
  import ipid_pkg::*;
#(
  parameter int IPID_W  = IPID_W_DFLT,
  parameter int CHUNK_W = CHUNK_W_DFLT,
  parameter int GAP_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               valid,
  input  logic [CHUNK_W-1:0] ipid_chunk,
  input  logic [IPID_W-1:0]  ipid_expected,
  output logic [IPID_W-1:0]  ipid_out,
  output logic               done,
  output logic               match,
  output logic               busy,
  output logic               error
);

  localparam int NCHUNK = IPID_W / CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int GAP_W  = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);
  localparam logic [GAP_W-1:0] GAP_LIM  = GAP_W'(GAP_MAX);

  ipid_asm_state_e   state, state_nxt;
  logic [IPID_W-1:0] shreg;
  logic [IPID_W-1:0] shreg_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [GAP_W-1:0]  gap;
  logic [GAP_W-1:0]  gap_inc;
  logic              collecting;
  logic              last_beat;
  logic              timeout;

  assign collecting = (state == COLLECT);
  assign shreg_nxt  = {shreg[IPID_W-CHUNK_W-1:0], ipid_chunk};
  assign gap_inc    = (gap == '1) ? gap : gap + 1'b1;
  // A coincident start always wins: it restarts the frame instead of completing or aborting it.
  assign last_beat  = collecting && !start && valid && (cnt == LAST_CNT);
  assign timeout    = collecting && !start && !valid && (GAP_MAX != 0) && (gap_inc == GAP_LIM);

  assign done = (state == DONE);
  assign busy = collecting;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: begin
        if (start)          state_nxt = COLLECT;
        else if (last_beat) state_nxt = DONE;
        else if (timeout)   state_nxt = IDLE;
      end
      DONE:    state_nxt = start ? COLLECT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      cnt      <= '0;
      gap      <= '0;
      ipid_out <= '0;
      match    <= 1'b0;
      error    <= 1'b0;
    end else if (start) begin
      shreg <= valid ? IPID_W'(ipid_chunk) : '0;
      cnt   <= CNT_W'(valid);
      gap   <= '0;
      match <= 1'b0;
      error <= 1'b0;
    end else if (collecting) begin
      if (valid) begin
        shreg <= shreg_nxt;
        cnt   <= cnt + 1'b1;
        gap   <= '0;
        if (last_beat) begin
          ipid_out <= shreg_nxt;
          match    <= (shreg_nxt == ipid_expected);
        end
      end else begin
        gap <= gap_inc;
        if (timeout) error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ipid_assemble.sv
// Randomized scoreboard bench for ipid_assemble against a frame-level reference model.
module tb_ipid_assemble;

  localparam int IPID_W  = 256;
  localparam int CHUNK_W = 16;
  localparam int GAP_MAX = 4;
  localparam int NCH     = IPID_W / CHUNK_W;
  localparam logic [255:0] GOLD =
    256'h33a344a35afd82155e5a6ef2d092085d704dc70561dde45d27962d79ea56a24a;

  logic               clk;
  logic               rst;
  logic               start;
  logic               valid;
  logic [CHUNK_W-1:0] ipid_chunk;
  logic [IPID_W-1:0]  ipid_expected;
  logic [IPID_W-1:0]  ipid_out;
  logic               done;
  logic               match;
  logic               busy;
  logic               error;

  ipid_assemble #(.IPID_W(IPID_W), .CHUNK_W(CHUNK_W), .GAP_MAX(GAP_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .ipid_chunk(ipid_chunk),
    .ipid_expected(ipid_expected), .ipid_out(ipid_out), .done(done), .match(match),
    .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned  cyc;
    logic [255:0] ipid;
    logic         m;
  } exp_t;

  exp_t        sb[$];
  exp_t        got;
  int unsigned mon_cyc = 0;
  int          checks  = 0;
  int          passes  = 0;
  bit          chk_en  = 0;

  // Reference model: chunks received since the last start, plus the visible output state.
  logic [15:0]  mq[$];
  bit           m_active = 0;
  int           m_gap    = 0;
  logic [255:0] m_ipid   = '0;
  bit           m_match  = 0;
  bit           m_err    = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, mon_cyc);
  endtask

  task automatic drive(input bit s, input bit v, input logic [15:0] c,
                       input logic [255:0] e, input bit r = 0);
    logic [255:0] val;
    @(negedge clk);
    rst = r; start = s; valid = v; ipid_chunk = c; ipid_expected = e;
    if (r) begin
      mq.delete(); m_active = 0; m_gap = 0; m_ipid = '0; m_match = 0; m_err = 0;
    end else if (s) begin
      mq.delete(); m_active = 1; m_gap = 0; m_match = 0; m_err = 0;
      if (v) mq.push_back(c);
    end else if (m_active) begin
      if (v) begin
        mq.push_back(c);
        m_gap = 0;
        if (mq.size() == NCH) begin
          val = '0;
          foreach (mq[i]) val = (val << 16) | 256'(mq[i]);
          m_ipid   = val;
          m_match  = (val == e);
          m_active = 0;
          sb.push_back('{mon_cyc + 1, val, m_match});
        end
      end else begin
        m_gap++;
        if (GAP_MAX != 0 && m_gap >= GAP_MAX) begin
          m_active = 0;
          m_err    = 1;
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic [255:0] e);
    for (int i = 0; i < n; i++) drive(0, 0, 16'($urandom), e);
  endtask

  task automatic send_frame(input logic [255:0] data, input logic [255:0] e,
                            input int gap_after = -1, input int gap_len = 0);
    for (int k = 0; k < NCH; k++) begin
      drive(k == 0, 1, data[255-16*k -: 16], e);
      if (k == gap_after) idle(gap_len, e);
    end
  endtask

  always @(posedge clk) begin
    #1;
    mon_cyc++;
    if (chk_en) begin
      check("busy", 256'(busy), 256'(m_active));
      check("error", 256'(error), 256'(m_err));
      check("ipid_out", ipid_out, m_ipid);
      check("match", 256'(match), 256'(m_match));
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL done_unexpected: got 1 required 0 (cycle %0d)", mon_cyc);
        end else begin
          got = sb.pop_front();
          check("done_cycle", 256'(mon_cyc), 256'(got.cyc));
          check("frame_ipid", ipid_out, got.ipid);
          check("frame_match", 256'(match), 256'(got.m));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= mon_cyc) begin
        checks++;
        $display("FAIL done_missing: got 0 required 1 (cycle %0d)", mon_cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] data;
    logic [255:0] e;
    int           gl;
    rst = 1; start = 0; valid = 0; ipid_chunk = '0; ipid_expected = '0;
    drive(0, 0, 0, 0, 1);
    chk_en = 1;
    drive(0, 0, 0, 0, 1);
    drive(0, 1, 16'h1234, 0, 1);
    idle(2, 0);

    // Back-to-back golden frame, then mismatch on flipped LSB.
    send_frame(GOLD, GOLD);
    idle(2, GOLD);
    send_frame(GOLD, GOLD ^ 256'd1);
    idle(2, GOLD);

    // Gap timeout after 5 chunks; the following start clears error.
    for (int k = 0; k < 5; k++) drive(k == 0, 1, GOLD[255-16*k -: 16], GOLD);
    idle(6, GOLD);
    send_frame(GOLD, GOLD);
    idle(1, GOLD);

    // Tolerated gap of 3 idles between chunks 7 and 8.
    send_frame(GOLD, GOLD, 7, 3);
    idle(2, GOLD);

    // Restart after 9 chunks of other data.
    for (int k = 0; k < 9; k++) drive(k == 0, 1, 16'($urandom), GOLD);
    send_frame(GOLD, GOLD);
    drive(0, 1, 16'hdead, GOLD);
    drive(0, 1, 16'hbeef, GOLD);
    idle(1, GOLD);

    // Reset mid-frame, then valids without start.
    for (int k = 0; k < 10; k++) drive(k == 0, 1, GOLD[255-16*k -: 16], GOLD);
    drive(0, 1, 16'h5555, GOLD, 1);
    for (int k = 0; k < 5; k++) drive(0, 1, 16'($urandom), GOLD);

    // Randomized frames with gaps, timeouts, restarts and overrun beats.
    for (int f = 0; f < 80; f++) begin
      data = '0;
      for (int i = 0; i < 8; i++) data = {data[223:0], 32'($urandom)};
      e = ($urandom % 2 == 0) ? data : data ^ (256'(1) << ($urandom % 256));
      for (int k = 0; k < NCH; k++) begin
        drive(k == 0 || ($urandom % 40 == 0), 1, data[255-16*k -: 16], e);
        if ($urandom % 8 == 0) begin
          gl = ($urandom % 6 == 0) ? GAP_MAX : $urandom_range(1, GAP_MAX - 1);
          idle(gl, e);
        end
      end
      for (int i = 0; i < int'($urandom % 3); i++) drive(0, $urandom % 2, 16'($urandom), e);
    end

    idle(3, 0);
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
